fetch_execute_queue: RTL and testbench

//  Parametrised decoupling queue between the fetch and execute stages. Replaces the bare

---
 rtl/fetch_execute_queue_pkg.sv | 23 ++
 rtl/fetch_execute_queue_if.sv | 41 ++++
 rtl/fetch_execute_queue_fifo_ctrl.sv | 83 ++++++++
 rtl/fetch_execute_queue.sv | 70 +++++++
 tb/tb_fetch_execute_queue.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_execute_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_execute_queue_pkg
//   Shared types for the fetch/execute decoupling queue.
//   - XLEN              : width of every fetch packet field
//   - word_t            : one XLEN-bit machine word
//   - fetch_packet_t    : packed {pc, instr, npc, prediction}
//   - FETCH_QUEUE_DEPTH : default queue depth (power of two, >= 2)
// -----------------------------------------------------------------------------
package fetch_execute_queue_pkg;

    localparam int XLEN              = 32;
    localparam int FETCH_QUEUE_DEPTH = 4;

    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
        word_t npc;
        word_t prediction;
    } fetch_packet_t;

endpackage : fetch_execute_queue_pkg

// File: rtl/fetch_execute_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_execute_queue_if
//   Fetch-side and execute-side handshake bundle around the decoupling queue.
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. f_ready depends only on queue occupancy; the producer must hold
//   f_* stable while f_valid=1 and f_ready=0. e_* are only meaningful while
//   e_valid=1 (they read as zero otherwise).
//   Modports:
//     master : the pipeline stages (drive f_* and e_ready, observe the rest)
//     slave  : the queue (accepts f_*, presents e_*)
// -----------------------------------------------------------------------------
interface fetch_execute_queue_if;
    import fetch_execute_queue_pkg::*;

    // fetch side
    logic  f_valid;
    logic  f_ready;
    word_t f_pc;
    word_t f_instr;
    word_t f_npc;
    word_t f_prediction;

    // execute side
    logic  e_valid;
    logic  e_ready;
    word_t e_pc;
    word_t e_instr;
    word_t e_npc;
    word_t e_prediction;

    modport master (
        output f_valid, f_pc, f_instr, f_npc, f_prediction, e_ready,
        input  f_ready, e_valid, e_pc, e_instr, e_npc, e_prediction
    );

    modport slave (
        input  f_valid, f_pc, f_instr, f_npc, f_prediction, e_ready,
        output f_ready, e_valid, e_pc, e_instr, e_npc, e_prediction
    );

endinterface : fetch_execute_queue_if

// File: rtl/fetch_execute_queue_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_execute_queue_fifo_ctrl
//   Generic pointer/occupancy controller for a DEPTH-entry circular FIFO.
//   Ports:
//     clk_i, rst_ni   : clock (rising edge), asynchronous active-low reset
//     flush_i         : clear pointers and count; overrides push/pop
//     push_i, pop_i   : raw requests (gated here by full/empty)
//     wr_en_o         : the storage should capture the write data this edge
//     wr_ptr_o        : slot to write
//     rd_ptr_o        : slot at the head
//     count_o         : occupied entries, 0..DEPTH
//     full_o, empty_o : derived from count only
// -----------------------------------------------------------------------------
module fetch_execute_queue_fifo_ctrl #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic             wr_en_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // Full refuses a push even if a pop frees a slot in the same cycle, so
    // f_ready never depends on the consumer.
    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i  & ~empty_o & ~flush_i;
    assign wr_en_o = push_ok;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by overflow.
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;

endmodule : fetch_execute_queue_fifo_ctrl

// File: rtl/fetch_execute_queue.sv
// -----------------------------------------------------------------------------
// fetch_execute_queue
//   DEPTH-entry decoupling FIFO of fetch packets between fetch and execute.
//   A packet pushed on edge N appears on e_* after edge N (no bypass).
//   Ports:
//     CLK   : clock, rising edge
//     nRST  : asynchronous active-low reset (empties the queue)
//     flush : discard every entry on this edge; push/pop in the cycle ignored
//     fe    : fetch/execute handshake bundle (slave side)
//     count : occupied entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_execute_queue
    import fetch_execute_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    flush,
    fetch_execute_queue_if.slave    fe,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_packet_t    mem_q [DEPTH];
    fetch_packet_t    head;
    logic             wr_en;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;

    fetch_execute_queue_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk_i    (CLK),
        .rst_ni   (nRST),
        .flush_i  (flush),
        .push_i   (fe.f_valid),
        .pop_i    (fe.e_ready),
        .wr_en_o  (wr_en),
        .wr_ptr_o (wr_ptr),
        .rd_ptr_o (rd_ptr),
        .count_o  (count),
        .full_o   (full),
        .empty_o  (empty)
    );

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= '{pc:         fe.f_pc,
                               instr:      fe.f_instr,
                               npc:        fe.f_npc,
                               prediction: fe.f_prediction};
        end
    end

    // Zero the head when empty so stale storage never leaks onto e_*.
    assign head = empty ? '0 : mem_q[rd_ptr];

    assign fe.f_ready      = ~full;
    assign fe.e_valid      = ~empty;
    assign fe.e_pc         = head.pc;
    assign fe.e_instr      = head.instr;
    assign fe.e_npc        = head.npc;
    assign fe.e_prediction = head.prediction;

endmodule : fetch_execute_queue

// File: tb/tb_fetch_execute_queue.sv
module tb_fetch_execute_queue;
  import fetch_execute_queue_pkg::*;

  logic       CLK;
  logic       nRST;
  logic       flush;
  logic [2:0] count;

  int vectors;
  int miscompares;

  logic [31:0] exp_q[$];

  fetch_execute_queue_if fe_if ();

  fetch_execute_queue #(
    .DEPTH (4)
  ) dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .flush (flush),
    .fe    (fe_if.slave),
    .count (count)
  );

  // clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // expected packet fields derived from the pc
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction
  function automatic logic [31:0] npc_of(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction
  function automatic logic [31:0] pred_of(input logic [31:0] pc);
    return pc + 32'h40;
  endfunction

  // scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, ".e_valid"}, 32'(fe_if.e_valid), 32'd1);
    chk({tag, ".e_pc"}, fe_if.e_pc, pc);
    chk({tag, ".e_instr"}, fe_if.e_instr, instr_of(pc));
    chk({tag, ".e_npc"}, fe_if.e_npc, npc_of(pc));
    chk({tag, ".e_pred"}, fe_if.e_prediction, pred_of(pc));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".e_valid"}, 32'(fe_if.e_valid), 32'd0);
    chk({tag, ".e_pc"}, fe_if.e_pc, 32'd0);
    chk({tag, ".f_ready"}, 32'(fe_if.f_ready), 32'd1);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc);
    fe_if.f_valid      = 1'b1;
    fe_if.f_pc         = pc;
    fe_if.f_instr      = instr_of(pc);
    fe_if.f_npc        = npc_of(pc);
    fe_if.f_prediction = pred_of(pc);
  endtask

  task automatic idle();
    fe_if.f_valid = 1'b0;
    fe_if.e_ready = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc);
    drive(pc);
    tick();
    fe_if.f_valid = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    nRST        = 1'b0;
    flush       = 1'b0;
    fe_if.f_valid      = 1'b0;
    fe_if.e_ready      = 1'b0;
    fe_if.f_pc         = '0;
    fe_if.f_instr      = '0;
    fe_if.f_npc        = '0;
    fe_if.f_prediction = '0;

    // reset state
    tick();
    tick();
    chk_empty("reset");
    nRST = 1'b1;
    tick();
    chk_empty("post_reset");

    // latency: no same-cycle bypass, visible after the pushing edge
    drive(32'h100);
    #1;
    chk("lat.before_edge.e_valid", 32'(fe_if.e_valid), 32'd0);
    tick();
    fe_if.f_valid = 1'b0;
    chk("lat.count", 32'(count), 32'd1);
    chk_head("lat", 32'h100);
    fe_if.e_ready = 1'b1;
    tick();
    fe_if.e_ready = 1'b0;
    chk_empty("lat.drained");

    // fill to DEPTH with execute stalled
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(4 * i));
    chk("fill.count", 32'(count), 32'd4);
    chk("fill.f_ready", 32'(fe_if.f_ready), 32'd0);
    push(32'h210);
    chk("fill.overflow.count", 32'(count), 32'd4);
    fe_if.e_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_head("fill.drain", 32'h200 + 32'(4 * i));
      tick();
    end
    fe_if.e_ready = 1'b0;
    chk_empty("fill.drained");

    // simultaneous push and pop at count=2, pointers wrap repeatedly
    push(32'h300);
    exp_q.push_back(32'h300);
    push(32'h304);
    exp_q.push_back(32'h304);
    chk("simul.start.count", 32'(count), 32'd2);
    for (int k = 0; k < 10; k++) begin
      drive(32'h308 + 32'(4 * k));
      fe_if.e_ready = 1'b1;
      #1;
      chk_head("simul.head", exp_q[0]);
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(32'h308 + 32'(4 * k));
      chk("simul.count", 32'(count), 32'd2);
    end
    idle();
    chk_head("simul.end", exp_q[0]);

    // flush beats a concurrent push and pop
    push(32'h400);
    chk("flush.pre.count", 32'(count), 32'd3);
    drive(32'h500);
    fe_if.e_ready = 1'b1;
    flush         = 1'b1;
    tick();
    idle();
    exp_q.delete();
    chk_empty("flush");
    push(32'h600);
    chk("flush.next.count", 32'(count), 32'd1);
    chk_head("flush.next", 32'h600);
    fe_if.e_ready = 1'b1;
    tick();
    fe_if.e_ready = 1'b0;
    chk_empty("flush.next.drained");

    // full plus pop: pop proceeds, push refused
    for (int i = 0; i < 4; i++) push(32'h700 + 32'(4 * i));
    drive(32'h710);
    fe_if.e_ready = 1'b1;
    #1;
    chk("fullpop.f_ready_before", 32'(fe_if.f_ready), 32'd0);
    tick();
    idle();
    chk("fullpop.count", 32'(count), 32'd3);
    chk("fullpop.f_ready", 32'(fe_if.f_ready), 32'd1);
    chk_head("fullpop.head", 32'h704);
    fe_if.e_ready = 1'b1;
    for (int i = 2; i < 4; i++) begin
      tick();
      chk_head("fullpop.drain", 32'h700 + 32'(4 * i));
    end
    tick();
    fe_if.e_ready = 1'b0;
    chk_empty("fullpop.refused_absent");

    // async reset mid-traffic
    push(32'h800);
    push(32'h804);
    drive(32'h808);
    chk("rst.pre.count", 32'(count), 32'd2);
    nRST = 1'b0;
    #1;
    chk_empty("rst.async");
    tick();
    idle();
    chk_empty("rst.held");
    nRST = 1'b1;
    tick();
    chk_empty("rst.released");
    push(32'h900);
    chk("rst.after.count", 32'(count), 32'd1);
    chk_head("rst.after", 32'h900);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
